stream_demux_32bit: RTL

Registered 1-to-2 stream demultiplexer, the inverse of the 32-bit two-input multiplexer. One input stream carries a 32-bit word plus a select bit. Each accepted word is steered into one of two independent output FIFOs, and each output drains through its own valid/ready handshake. It sits between a producer stage and two consumers that may stall independently, for example two write-back or forwarding targets in the MIPS datapath.

---
 rtl/stream_demux_32bit.sv | 104 ++++++++++
 1 files changed

// File: rtl/stream_demux_32bit.sv
// Registered 1-to-2 stream demultiplexer: each accepted word is steered by in_sel
// into one of two independent circular FIFOs, each drained through its own valid/ready.
module stream_demux_32bit #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_val,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [CW-1:0]    out0_count,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CW-1:0]    out1_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q    [2][DEPTH];
   logic [WIDTH-1:0] mem_d    [2][DEPTH];
   logic [AW-1:0]    wr_ptr_q [2];
   logic [AW-1:0]    wr_ptr_d [2];
   logic [AW-1:0]    rd_ptr_q [2];
   logic [AW-1:0]    rd_ptr_d [2];
   logic [CW-1:0]    count_q  [2];
   logic [CW-1:0]    count_d  [2];

   logic [1:0] full;
   logic [1:0] push;
   logic [1:0] pop;
   logic [1:0] out_ready;

   assign out_ready = {out1_ready, out0_ready};

   // in_ready looks only at the selected channel's registered count, so a pop
   // in the same cycle never opens a slot for a full channel.
   always_comb begin
      for (int unsigned k = 0; k < 2; k++) begin
         full[k] = (count_q[k] == CW'(DEPTH));
      end
      in_ready = in_sel ? ~full[1] : ~full[0];
      push[0]  = in_valid & in_ready & ~in_sel;
      push[1]  = in_valid & in_ready &  in_sel;
      for (int unsigned k = 0; k < 2; k++) begin
         pop[k] = (count_q[k] != '0) & out_ready[k];
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      for (int unsigned k = 0; k < 2; k++) begin
         if (push[k]) begin
            mem_d[k][wr_ptr_q[k]] = in_val;
            wr_ptr_d[k]           = wr_ptr_q[k] + 1'b1;
         end
         if (pop[k]) begin
            rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
         end
         case ({push[k], pop[k]})
            2'b10:   count_d[k] = count_q[k] + 1'b1;
            2'b01:   count_d[k] = count_q[k] - 1'b1;
            default: count_d[k] = count_q[k];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < 2; k++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               mem_q[k][i] <= '0;
            end
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            count_q[k]  <= '0;
         end
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      out0_data  = mem_q[0][rd_ptr_q[0]];
      out1_data  = mem_q[1][rd_ptr_q[1]];
      out0_count = count_q[0];
      out1_count = count_q[1];
      out0_valid = (count_q[0] != '0);
      out1_valid = (count_q[1] != '0);
   end

endmodule
